// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access encodings, FSM states
// and the load lane-select/extend helper.
package mem_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LBU = 3'b001;
    localparam logic [2:0] MEMOP_LH  = 3'b010;
    localparam logic [2:0] MEMOP_LHU = 3'b011;
    localparam logic [2:0] MEMOP_LW  = 3'b100;
    localparam logic [2:0] MEMOP_SB  = 3'b101;
    localparam logic [2:0] MEMOP_SH  = 3'b110;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    function automatic logic op_is_half(input logic [2:0] op);
        return (op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH);
    endfunction

    // The unused 3'b111 encoding is handled as a full-word access.
    function automatic logic op_is_word(input logic [2:0] op);
        return (op == MEMOP_LW) || (op == 3'b111);
    endfunction

    // Pick the addressed byte/half out of a RAM word and sign/zero extend it.
    function automatic logic [DATA_W-1:0] lane_extend(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        off,
                                                      input logic [2:0]        op);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            MEMOP_LB:  return {{24{b[7]}}, b};
            MEMOP_LBU: return {24'd0, b};
            MEMOP_LH:  return {{16{h[15]}}, h};
            MEMOP_LHU: return {16'd0, h};
            default:   return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_dm_ram.sv
// Data memory: byte-enabled writes, synchronous registered read, write-first
// on a same-word read/write collision.
module dm_ram
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              re,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged_c;

    // Word as it will look after this cycle's write, used for write-first reads.
    always_comb begin
        merged_c = mem[addr];
        for (int i = 0; i < 4; i++) begin
            if (we[i]) merged_c[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (clr)     rdata <= '0;
        else if (re) rdata <= merged_c;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: aligned byte/half/word stores in one cycle,
// loads in two cycles with a one-cycle pipeline stall.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        MemOp,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] dmOut,
    output logic              stall,
    output logic              align_err
);

    state_t            state, state_nxt;
    logic [1:0]        off_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] rdata;
    logic [3:0]        we_c;
    logic              re_c;
    logic              misalign_c;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wrep_c;
    logic              unused_addr_c;

    assign unused_addr_c = ^alu_out[DATA_W-1:ADDR_W+2];

    assign misalign_c = (op_is_half(MemOp) && alu_out[0]) ||
                        (op_is_word(MemOp) && (alu_out[1:0] != 2'b00));

    // Byte enables and lane-replicated store data.
    always_comb begin
        be_c   = 4'(4'b0001 << alu_out[1:0]);
        wrep_c = {4{wdata[7:0]}};
        if (op_is_word(MemOp)) begin
            be_c   = 4'b1111;
            wrep_c = wdata;
        end else if (op_is_half(MemOp)) begin
            be_c   = alu_out[1] ? 4'b1100 : 4'b0011;
            wrep_c = {2{wdata[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
            off_q <= 2'b00;
            op_q  <= MEMOP_LW;
        end else begin
            state <= state_nxt;
            if (re_c) begin
                off_q <= alu_out[1:0];
                op_q  <= MemOp;
            end
        end
    end

    // Store wins over load when both are requested; reset suppresses everything.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        align_err = 1'b0;
        we_c      = 4'b0000;
        re_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!clr && (MemRead || MemWrite)) begin
                    if (misalign_c) begin
                        align_err = 1'b1;
                    end else if (MemWrite) begin
                        we_c = be_c;
                    end else begin
                        re_c      = 1'b1;
                        stall     = 1'b1;
                        state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    dm_ram #(.ADDR_W(ADDR_W)) u_dm_ram (
        .clk   (clk),
        .clr   (clr),
        .re    (re_c),
        .we    (we_c),
        .addr  (alu_out[ADDR_W+1:2]),
        .wdata (wrep_c),
        .rdata (rdata)
    );

    assign dmOut = lane_extend(rdata, off_q, op_q);

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  MemOp;
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic [31:0] dmOut;
    logic        stall;
    logic        align_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(10)) dut (
        .clk       (clk),
        .clr       (clr),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemOp     (MemOp),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .dmOut     (dmOut),
        .stall     (stall),
        .align_err (align_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d);
        MemRead  = rd;
        MemWrite = wr;
        MemOp    = op;
        alu_out  = a;
        wdata    = d;
    endtask

    task automatic do_store(input string tag, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, op, a, d);
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_aerr"}, 32'(align_err), 32'd0);
        step();
    endtask

    // Load inputs stay asserted through RD_WAIT, as a frozen EX/MEM would hold them.
    task automatic do_load(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, op, a, 32'd0);
        #1;
        chk({tag, "_stall1"}, 32'(stall), 32'd1);
        step();
        chk({tag, "_stall2"}, 32'(stall), 32'd0);
        chk({tag, "_data"}, dmOut, exp);
        step();
    endtask

    initial begin
        clr = 1'b1;
        drive(1'b0, 1'b0, MEMOP_LW, 32'd0, 32'd0);
        step();
        step();
        clr = 1'b0;
        #1;
        chk("rst_dmout", dmOut, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_aerr", 32'(align_err), 32'd0);

        do_store("sw10", MEMOP_LW, 32'h10, 32'h8899AABB);
        do_load("lw10", MEMOP_LW, 32'h10, 32'h8899AABB);

        do_store("sb13", MEMOP_SB, 32'h13, 32'h000000F0);
        do_load("lb13", MEMOP_LB, 32'h13, 32'hFFFFFFF0);
        do_load("lbu13", MEMOP_LBU, 32'h13, 32'h000000F0);
        do_load("lw10b", MEMOP_LW, 32'h10, 32'hF099AABB);
        do_load("lb11", MEMOP_LB, 32'h11, 32'hFFFFFFAA);
        do_load("lbu12", MEMOP_LBU, 32'h12, 32'h00000099);

        do_store("sw20", MEMOP_LW, 32'h20, 32'h55667788);
        do_store("sh22", MEMOP_SH, 32'h22, 32'h00001234);
        do_load("lh22", MEMOP_LH, 32'h22, 32'h00001234);
        do_load("lhu20", MEMOP_LHU, 32'h20, 32'h00007788);
        do_load("lh20", MEMOP_LH, 32'h20, 32'h00007788);
        do_store("sh20", MEMOP_SH, 32'h20, 32'hFFFF9ABC);
        do_load("lh20n", MEMOP_LH, 32'h20, 32'hFFFF9ABC);
        do_load("lhu20n", MEMOP_LHU, 32'h20, 32'h00009ABC);

        // Misaligned word load: flagged, no stall, dmOut held.
        drive(1'b1, 1'b0, MEMOP_LW, 32'h11, 32'd0);
        #1;
        chk("lw11_aerr", 32'(align_err), 32'd1);
        chk("lw11_stall", 32'(stall), 32'd0);
        step();
        chk("lw11_hold", dmOut, 32'h00009ABC);
        drive(1'b1, 1'b0, MEMOP_LH, 32'h21, 32'd0);
        #1;
        chk("lh21_aerr", 32'(align_err), 32'd1);
        step();
        drive(1'b0, 1'b1, MEMOP_SH, 32'h23, 32'h0000AAAA);
        #1;
        chk("sh23_aerr", 32'(align_err), 32'd1);
        chk("sh23_stall", 32'(stall), 32'd0);
        step();
        drive(1'b0, 1'b0, MEMOP_LW, 32'h0, 32'd0);
        #1;
        chk("idle_aerr", 32'(align_err), 32'd0);
        do_load("lw20", MEMOP_LW, 32'h20, 32'h12349ABC);

        // Read+write together behaves as a store.
        drive(1'b1, 1'b1, MEMOP_LW, 32'h30, 32'h0BADF00D);
        #1;
        chk("rw30_stall", 32'(stall), 32'd0);
        step();
        do_load("lw30", MEMOP_LW, 32'h30, 32'h0BADF00D);

        do_store("sw1000", MEMOP_LW, 32'h1000, 32'hDEADBEEF);
        do_load("lw0", MEMOP_LW, 32'h0, 32'hDEADBEEF);

        // Reset in the RD_WAIT cycle abandons the load but keeps RAM.
        do_store("sw40", MEMOP_LW, 32'h40, 32'hCAFEF00D);
        drive(1'b1, 1'b0, MEMOP_LW, 32'h40, 32'd0);
        #1;
        chk("lw40_stall1", 32'(stall), 32'd1);
        step();
        clr = 1'b1;
        #1;
        chk("clr_stall", 32'(stall), 32'd0);
        step();
        drive(1'b1, 1'b0, MEMOP_LW, 32'h11, 32'd0);
        #1;
        chk("clr_aerr", 32'(align_err), 32'd0);
        chk("clr_stall2", 32'(stall), 32'd0);
        clr = 1'b0;
        drive(1'b0, 1'b0, MEMOP_LW, 32'h0, 32'd0);
        #1;
        chk("post_clr_dmout", dmOut, 32'd0);
        chk("post_clr_stall", 32'(stall), 32'd0);
        chk("post_clr_aerr", 32'(align_err), 32'd0);
        step();
        do_load("lw40", MEMOP_LW, 32'h40, 32'hCAFEF00D);
        do_load("lw10c", MEMOP_LW, 32'h10, 32'hF099AABB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline; sits between the EX/MEM pipeline register and mem2wb.
- Owns the data memory and performs byte/half/word loads and stores, with sign or zero extension.
- Produces dmOut, which feeds the dmOut input of mem2wb.
- The RAM read is synchronous, so every load takes two cycles. The block stalls the pipeline for the first cycle.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words.

Ports:
- clk  input  1  pipeline clock; everything updates on the rising edge.
- clr  input  1  synchronous, active-high reset.
- MemRead  input  1  current EX/MEM instruction is a load.
- MemWrite  input  1  current EX/MEM instruction is a store.
- MemOp  input  3  access type: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW/SW, 101 SB, 110 SH.
- alu_out  input  32  byte address.
- wdata  input  32  store data; right-aligned (byte in [7:0], half in [15:0]).
- dmOut  output  32  extended load result; goes to mem2wb.
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- align_err  output  1  misaligned access detected; no memory effect.

Behaviour:
- Word index = alu_out[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- State machine, two states: IDLE and RD_WAIT. Reset value is IDLE.
- Misaligned access:
  - Halfword with alu_out[0]=1, or word with alu_out[1:0]≠0.
  - Only evaluated in IDLE.
  - align_err is driven combinationally.
  - No read or write happens, stall=0, and dmOut is unchanged.
- Store (IDLE, MemWrite=1, aligned):
  - Byte enables come from MemOp and alu_out[1:0]: SB sets one lane, SH sets lanes 0-1 or 2-3, SW sets all four.
  - wdata is replicated into the selected lanes.
  - RAM is written at the clock edge. No stall; effectively one-cycle latency.
- MemRead and MemWrite both 1: treated as a store; the read is ignored.
- Load issue (IDLE, MemRead=1, MemWrite=0, aligned):
  - stall=1 combinationally in cycle N.
  - At the edge: the RAM word is captured into the read register, alu_out[1:0] and MemOp are latched, and state goes to RD_WAIT.
- RD_WAIT (cycle N+1):
  - stall=0.
  - dmOut = lane selected by the latched offset, extended per the latched MemOp (LB/LH sign-extend, LBU/LHU zero-extend).
  - Inputs are ignored, so the held load is not reissued.
  - Next state is IDLE unconditionally; mem2wb captures dmOut at the end of N+1.
- dmOut is combinational from the read register plus latched offset/op. It holds its last value until the next load completes.
- Back-to-back loads: the second load issues in the IDLE cycle after RD_WAIT, so each load costs 2 cycles.
- Reset (clr=1 at an edge):
  - State goes to IDLE; read register, latched offset and latched op are cleared (op cleared = LW encoding).
  - So dmOut=0, stall=0 and align_err=0 in the cycle after.
  - RAM contents are not cleared.
  - Reset during RD_WAIT abandons the load and dmOut becomes 0.
- stall and align_err are forced to 0 while clr=1.

Decomposition:
- Package mem_pkg holds: MemOp encodings (MEMOP_LB … MEMOP_SH), state encodings, and the lane-select/extend function.
- One sub-module, dm_ram:
  - 2**ADDR_W × 32 storage with 4 byte-write enables.
  - Synchronous read into a registered output.
  - Write-first when reading and writing the same word in the same cycle.

Test Plan:
- SW wdata=0x8899AABB @0x10, then LW @0x10 → stall=1 for exactly one cycle; next cycle dmOut=0x8899AABB, stall=0.
- SB 0x000000F0 @0x13, then LB @0x13 → dmOut=0xFFFFFFF0; LBU @0x13 → 0x000000F0; LW @0x10 → 0xF099AABB.
- SH 0x00001234 @0x22, then LH @0x22 → 0x00001234; LHU @0x20 → lower half unchanged from prior contents.
- LW @0x11 → align_err=1, stall=0, dmOut unchanged; SH @0x23 → align_err=1, memory word @0x20 unchanged.
- Address wrap with ADDR_W=10: SW 0xDEADBEEF @0x1000 → LW @0x0 returns 0xDEADBEEF.
- Assert clr in the RD_WAIT cycle of a LW → next cycle state IDLE, dmOut=0, stall=0; a following LW returns the stored data, confirming RAM retention.
